// File: rtl/led_matrix_pkg.sv
// Shared types and pixel-field helpers for the LED matrix scan block.
package led_matrix_pkg;

   // Scan sequencer states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SHIFT   = 3'd1,
      ST_BLANK   = 3'd2,
      ST_LATCH   = 3'd3,
      ST_DISPLAY = 3'd4
   } scan_state_e;

   // Channel order inside a packed {R,G,B} pixel word (R in the top field)
   localparam int unsigned CH_B = 0;
   localparam int unsigned CH_G = 1;
   localparam int unsigned CH_R = 2;

   // LSB position of a colour channel in a pixel word of the given depth
   function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned depth);
      return ch * depth;
   endfunction

endpackage

// File: rtl/led_matrix_bcm_timer.sv
// Binary-code-modulation plane timing: the DISPLAY length of a plane and
// whether the panel output is enabled at the current count.
// With LED_MATRIX_GLOBAL_DIM_EN defined, a global dim level gates the
// enabled portion of each plane without changing its length.
module led_matrix_bcm_timer #(
   parameter int unsigned BASE_TICKS = 8,
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned PLANE_W    = 2
) (
   input  logic [PLANE_W-1:0] plane_i,
   input  logic [CNT_W-1:0]   count_i,
`ifdef LED_MATRIX_GLOBAL_DIM_EN
   input  logic [7:0]         dim_i,
`endif
   output logic               last_o,
   output logic               oe_on_o
);

   logic [CNT_W-1:0] duration;

   // Plane p lasts BASE_TICKS << p cycles; last_o marks its final cycle
   always_comb begin
      duration = CNT_W'(BASE_TICKS) << plane_i;
      last_o   = (count_i == duration - 1'b1);
   end

`ifdef LED_MATRIX_GLOBAL_DIM_EN
   logic [CNT_W+8:0] prod;
   logic [CNT_W+8:0] thresh;

   // Output enabled only for the first (duration*(dim+1))/256 cycles
   always_comb begin
      prod    = (CNT_W+9)'(duration) * ((CNT_W+9)'(dim_i) + 1'b1);
      thresh  = prod >> 8;
      oe_on_o = ((CNT_W+9)'(count_i) < thresh);
   end
`else
   assign oe_on_o = 1'b1;
`endif

endmodule

// File: rtl/led_matrix_scan.sv
// HUB75-style LED matrix scanner: shifts one row pair per BCM plane,
// blanks, latches, then displays for a plane-weighted time.
// Optional macro LED_MATRIX_GLOBAL_DIM_EN adds a global dim input.
module led_matrix_scan
   import led_matrix_pkg::*;
#(
   parameter int unsigned COLS       = 32,
   parameter int unsigned ROW_BITS   = 3,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CLK_DIV    = 2,
   parameter int unsigned BASE_TICKS = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable,
`ifdef LED_MATRIX_GLOBAL_DIM_EN
   input  logic [7:0]                        dim,
`endif
   output logic                              pix_rd,
   output logic [ROW_BITS+$clog2(COLS)-1:0]  pix_addr,
   input  logic [3*DEPTH-1:0]                pix_data0,
   input  logic [3*DEPTH-1:0]                pix_data1,
   output logic [2:0]                        rgb0,
   output logic [2:0]                        rgb1,
   output logic                              rgb_clk,
   output logic                              rgb_lat,
   output logic                              rgb_oe_n,
   output logic [ROW_BITS-1:0]               rgb_addr,
   output logic                              frame_done
);

   localparam int unsigned COL_W   = $clog2(COLS);
   localparam int unsigned CYC_W   = $clog2(2 * CLK_DIV);
   localparam int unsigned CNT_W   = $clog2(BASE_TICKS << (DEPTH - 1)) + 1;
   localparam int unsigned PLANE_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [CYC_W-1:0]    CYC_LAST   = CYC_W'(2 * CLK_DIV - 1);
   localparam logic [CYC_W-1:0]    CYC_HI     = CYC_W'(CLK_DIV);
   localparam logic [CYC_W-1:0]    CYC_CAP    = CYC_W'(1);
   localparam logic [COL_W-1:0]    COL_LAST   = COL_W'(COLS - 1);
   localparam logic [PLANE_W-1:0]  PLANE_LAST = PLANE_W'(DEPTH - 1);
   localparam logic [ROW_BITS-1:0] ROW_LAST   = '1;

   scan_state_e          state_q, state_d;
   logic [ROW_BITS-1:0]  row_q, row_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic [CYC_W-1:0]     cyc_q, cyc_d;
   logic [PLANE_W-1:0]   plane_q, plane_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2:0]           rgb0_q, rgb0_d;
   logic [2:0]           rgb1_q, rgb1_d;
   logic [ROW_BITS-1:0]  addr_q, addr_d;
   logic                 frame_done_q, frame_done_d;

   logic                 disp_last;
   logic                 disp_oe_on;
   logic [2:0]           bits0, bits1;
   logic [DEPTH-1:0]     r0, g0, b0, r1, g1, b1;

   led_matrix_bcm_timer #(
      .BASE_TICKS (BASE_TICKS),
      .CNT_W      (CNT_W),
      .PLANE_W    (PLANE_W)
   ) u_bcm_timer (
      .plane_i (plane_q),
      .count_i (cnt_q),
`ifdef LED_MATRIX_GLOBAL_DIM_EN
      .dim_i   (dim),
`endif
      .last_o  (disp_last),
      .oe_on_o (disp_oe_on)
   );

   // Pick the current plane's bit out of each colour channel
   always_comb begin
      r0    = pix_data0[chan_lsb(CH_R, DEPTH) +: DEPTH];
      g0    = pix_data0[chan_lsb(CH_G, DEPTH) +: DEPTH];
      b0    = pix_data0[chan_lsb(CH_B, DEPTH) +: DEPTH];
      r1    = pix_data1[chan_lsb(CH_R, DEPTH) +: DEPTH];
      g1    = pix_data1[chan_lsb(CH_G, DEPTH) +: DEPTH];
      b1    = pix_data1[chan_lsb(CH_B, DEPTH) +: DEPTH];
      bits0 = {r0[plane_q], g0[plane_q], b0[plane_q]};
      bits1 = {r1[plane_q], g1[plane_q], b1[plane_q]};
   end

   // State and counter registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         cyc_q        <= '0;
         plane_q      <= '0;
         cnt_q        <= '0;
         rgb0_q       <= '0;
         rgb1_q       <= '0;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         cyc_q        <= cyc_d;
         plane_q      <= plane_d;
         cnt_q        <= cnt_d;
         rgb0_q       <= rgb0_d;
         rgb1_q       <= rgb1_d;
         addr_q       <= addr_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Next-state logic; dropping enable returns to IDLE from any state
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      cyc_d        = cyc_q;
      plane_d      = plane_q;
      cnt_d        = cnt_q;
      rgb0_d       = rgb0_q;
      rgb1_d       = rgb1_q;
      addr_d       = addr_q;
      frame_done_d = 1'b0;

      if (!enable) begin
         state_d = ST_IDLE;
         row_d   = '0;
         col_d   = '0;
         cyc_d   = '0;
         plane_d = '0;
         cnt_d   = '0;
         rgb0_d  = '0;
         rgb1_d  = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_SHIFT;
               row_d   = '0;
               col_d   = '0;
               cyc_d   = '0;
               plane_d = '0;
               cnt_d   = '0;
            end
            ST_SHIFT: begin
               // pixel data returns one cycle after the read strobe
               if (cyc_q == CYC_CAP) begin
                  rgb0_d = bits0;
                  rgb1_d = bits1;
               end
               if (cyc_q == CYC_LAST) begin
                  cyc_d = '0;
                  if (col_q == COL_LAST) begin
                     col_d   = '0;
                     state_d = ST_BLANK;
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  cyc_d = cyc_q + 1'b1;
               end
            end
            ST_BLANK: begin
               addr_d  = row_q;
               state_d = ST_LATCH;
            end
            ST_LATCH: begin
               cnt_d   = '0;
               state_d = ST_DISPLAY;
            end
            ST_DISPLAY: begin
               if (disp_last) begin
                  cnt_d   = '0;
                  state_d = ST_SHIFT;
                  if (plane_q == PLANE_LAST) begin
                     plane_d = '0;
                     row_d   = row_q + 1'b1;
                     if (row_q == ROW_LAST) begin
                        frame_done_d = 1'b1;
                     end
                  end else begin
                     plane_d = plane_q + 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Panel and pixel-store outputs decoded from the registered state
   always_comb begin
      pix_rd     = (state_q == ST_SHIFT) && (cyc_q == '0);
      pix_addr   = {row_q, col_q};
      rgb_clk    = (state_q == ST_SHIFT) && (cyc_q >= CYC_HI);
      rgb_lat    = (state_q == ST_LATCH);
      rgb_oe_n   = !((state_q == ST_DISPLAY) && disp_oe_on);
      rgb0       = rgb0_q;
      rgb1       = rgb1_q;
      rgb_addr   = addr_q;
      frame_done = frame_done_q;
   end

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan with a 4-column, 2-row-pair panel.
// Build with LED_MATRIX_GLOBAL_DIM_EN to also exercise the dim input.
module tb_led_matrix_scan;

   localparam int COLS = 4;
   localparam int ROW_BITS = 1;
   localparam int DEPTH = 4;
   localparam int CLK_DIV = 2;
   localparam int BASE_TICKS = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        pix_rd;
   logic [2:0]  pix_addr;
   logic [11:0] pix_data0 = 12'hA50;
   logic [11:0] pix_data1;
   logic [2:0]  rgb0, rgb1;
   logic        rgb_clk, rgb_lat, rgb_oe_n;
   logic [0:0]  rgb_addr;
   logic        frame_done;
`ifdef LED_MATRIX_GLOBAL_DIM_EN
   logic [7:0]  dim = 8'd255;
`endif

   int n_checks = 0;
   int n_fail = 0;
   int dim_v = 255;

   led_matrix_scan #(
      .COLS       (COLS),
      .ROW_BITS   (ROW_BITS),
      .DEPTH      (DEPTH),
      .CLK_DIV    (CLK_DIV),
      .BASE_TICKS (BASE_TICKS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
`ifdef LED_MATRIX_GLOBAL_DIM_EN
      .dim        (dim),
`endif
      .pix_rd     (pix_rd),
      .pix_addr   (pix_addr),
      .pix_data0  (pix_data0),
      .pix_data1  (pix_data1),
      .rgb0       (rgb0),
      .rgb1       (rgb1),
      .rgb_clk    (rgb_clk),
      .rgb_lat    (rgb_lat),
      .rgb_oe_n   (rgb_oe_n),
      .rgb_addr   (rgb_addr),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Lower-half pixel store: one-cycle read latency, address-dependent data
   function automatic logic [11:0] pix1_of(input logic [2:0] a);
      logic [3:0] r, g, b;
      r = {1'b0, a} ^ 4'h9;
      g = ~{1'b0, a};
      b = {a, 1'b1};
      return {r, g, b};
   endfunction

   logic [2:0] rd_addr = '0;
   always @(posedge clk) if (pix_rd) rd_addr <= pix_addr;
   assign pix_data1 = pix1_of(rd_addr);

   // R=A, G=5, B=0 upper pixel, per-plane {R,G,B} bits worked by hand
   function automatic logic [2:0] exp_rgb0(input int p);
      case (p)
         0: return 3'b010;
         1: return 3'b100;
         2: return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] exp_rgb1(input int r, input int c, input int p);
      logic [11:0] w;
      logic [3:0] rs, gs, bs;
      w = pix1_of(3'(r * 4 + c));
      rs = w[11:8] >> p;
      gs = w[7:4] >> p;
      bs = w[3:0] >> p;
      return {rs[0], gs[0], bs[0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Called at the negedge of the first SHIFT cycle; returns at the next one
   task automatic run_plane(input int r, input int p);
      logic [3:0] clkv, rdv, oev;
      logic [2:0] addr, g0, g1;
      int lo, hi, dur, exp_lo;
      for (int c = 0; c < COLS; c++) begin
         clkv = '0; rdv = '0; oev = '0; addr = '0; g0 = '0; g1 = '0;
         for (int k = 0; k < 2 * CLK_DIV; k++) begin
            clkv[k] = rgb_clk;
            rdv[k]  = pix_rd;
            oev[k]  = rgb_oe_n;
            if (k == 0) addr = pix_addr;
            if (k == 3) begin g0 = rgb0; g1 = rgb1; end
            @(negedge clk);
         end
         check("shift_clk", 32'(clkv), 32'b1100);
         check("pix_rd", 32'(rdv), 32'b0001);
         check("oe_shift", 32'(oev), 32'b1111);
         check("pix_addr", 32'(addr), 32'(r * 4 + c));
         check("rgb0", 32'(g0), 32'(exp_rgb0(p)));
         check("rgb1", 32'(g1), 32'(exp_rgb1(r, c, p)));
      end
      check("blank_clk", 32'(rgb_clk), 0);
      check("blank_oe", 32'(rgb_oe_n), 1);
      check("blank_lat", 32'(rgb_lat), 0);
      @(negedge clk);
      check("latch", 32'(rgb_lat), 1);
      check("latch_oe", 32'(rgb_oe_n), 1);
      check("rgb_addr", 32'(rgb_addr), 32'(r));
      @(negedge clk);
      lo = 0;
      while (rgb_oe_n == 1'b0 && lo < 2000) begin
         lo++;
         @(negedge clk);
      end
      hi = 0;
      while (rgb_oe_n == 1'b1 && pix_rd == 1'b0 && hi < 2000) begin
         hi++;
         @(negedge clk);
      end
      dur = BASE_TICKS << p;
      exp_lo = (dur * (dim_v + 1)) >> 8;
      check("oe_low", 32'(lo), 32'(exp_lo));
      check("oe_high", 32'(hi), 32'(dur - exp_lo));
      check("frame_done", 32'(frame_done), 32'((r == 1 && p == DEPTH - 1) ? 1 : 0));
   endtask

   initial begin
      // reset with enable low
      #12;
      check("rst_pix_rd", 32'(pix_rd), 0);
      check("rst_pix_addr", 32'(pix_addr), 0);
      check("rst_clk", 32'(rgb_clk), 0);
      check("rst_lat", 32'(rgb_lat), 0);
      check("rst_oe", 32'(rgb_oe_n), 1);
      check("rst_rgb", 32'({rgb0, rgb1}), 0);
      check("rst_addr", 32'(rgb_addr), 0);
      check("rst_fd", 32'(frame_done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_rd", 32'(pix_rd), 0);
      check("idle_oe", 32'(rgb_oe_n), 1);
      check("idle_clk", 32'(rgb_clk), 0);

      // full frame then wrap to row 0
      enable = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < DEPTH; p++)
            run_plane(r, p);
      run_plane(0, 0);

      // drop enable mid-SHIFT (column 1, second cycle)
      repeat (5) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("dis_clk", 32'(rgb_clk), 0);
      check("dis_oe", 32'(rgb_oe_n), 1);
      check("dis_rd", 32'(pix_rd), 0);
      check("dis_lat", 32'(rgb_lat), 0);
      check("dis_addr", 32'(pix_addr), 0);
      repeat (3) @(negedge clk);
      check("dis_hold_rd", 32'(pix_rd), 0);
      enable = 1'b1;
      @(negedge clk);
      run_plane(0, 0);
      for (int p = 1; p < DEPTH; p++) run_plane(0, p);

      // asynchronous reset during row 1 DISPLAY
      repeat (4 * COLS + 5) @(negedge clk);
      check("pre_rst_oe", 32'(rgb_oe_n), 0);
      rst_n = 1'b0;
      #1;
      check("arst_oe", 32'(rgb_oe_n), 1);
      check("arst_addr", 32'(rgb_addr), 0);
      check("arst_rgb", 32'({rgb0, rgb1}), 0);
      check("arst_pix_addr", 32'(pix_addr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_plane(0, 0);

`ifdef LED_MATRIX_GLOBAL_DIM_EN
      dim = 8'd127;
      dim_v = 127;
      run_plane(0, 1);
      run_plane(0, 2);
      run_plane(0, 3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
